// File: rtl/umi_isolate_ctrl_pkg.sv
// Shared types and constants for the UMI power-domain isolation controller.
// Holds the controller state encoding and the response-expecting opcode list.
package umi_isolate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISO   = 3'd2,
    ST_OFF   = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] UMI_REQ_READ   = 5'h01;
  localparam logic [OPW-1:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [OPW-1:0] UMI_REQ_ATOMIC = 5'h09;

  function automatic logic resp_expected(
    input logic [OPW-1:0] op
  );
    return (op == UMI_REQ_READ)
         | (op == UMI_REQ_WRITE)
         | (op == UMI_REQ_ATOMIC);
  endfunction

endpackage

// File: rtl/umi_isolate_ctrl.sv
// Drains, isolates and wakes a UMI power domain on pwr_req.
// Optional drain timeout: define UMI_ISOLATE_CTRL_TIMEOUT_EN.
module umi_isolate_ctrl
  import umi_isolate_ctrl_pkg::*;
#(
  parameter int CW      = 32,
  parameter int OW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          pwr_req,
  output logic          pwr_ack,
  output logic          isolate,
  input  logic          host_req_valid,
  input  logic [CW-1:0] host_req_cmd,
  output logic          host_req_ready,
  output logic          dev_req_valid,
  input  logic          dev_req_ready,
  input  logic          resp_valid,
  input  logic          resp_ready,
  output logic [OW-1:0] outstanding
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int SW = $clog2(SETTLE + 1);

  state_t        state;
  logic          hold;
  logic [SW-1:0] settle_cnt;

  logic gate_open;
  logic full;
  logic req_hs;
  logic inc;
  logic dec;
  logic drain_done;
  logic settle_last;
  logic tmo_hit;
  logic unused_cmd;

  assign unused_cmd = ^host_req_cmd[CW-1:OPW];

  assign full = (outstanding == {OW{1'b1}});

  assign gate_open = (state == ST_ON)
                   | ((state == ST_DRAIN) & hold);

  assign dev_req_valid  = host_req_valid & gate_open & ~full;
  assign host_req_ready = dev_req_ready & gate_open & ~full;

  assign req_hs = host_req_valid & host_req_ready;
  assign inc    = req_hs & resp_expected(host_req_cmd[OPW-1:0]);
  assign dec    = resp_valid & resp_ready;

  assign drain_done = ~hold
                    & (outstanding == '0)
                    & ~resp_valid;

  assign settle_last = (settle_cnt == SW'(SETTLE - 1));

`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT + 1);

  logic [DW-1:0] drain_cnt;

  assign tmo_hit = (state == ST_DRAIN)
                 & pwr_req
                 & ~drain_done
                 & (drain_cnt == DW'(TIMEOUT - 1));

  // Count cycles spent in DRAIN; zero everywhere else.
  always_ff @(posedge clk) begin
    if (!nreset || state != ST_DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DW'(1);
    end
  end

  // Sticky flag raised when a drain is forced by the timeout.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Outstanding-response tracker; forced to zero while powered off.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      outstanding <= '0;
    end else if (state == ST_OFF || tmo_hit) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + OW'(1);
    end else if (dec && !inc && outstanding != '0) begin
      outstanding <= outstanding - OW'(1);
    end
  end

  // Power sequencing FSM with registered isolate/pwr_ack.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= ST_ON;
      isolate    <= 1'b0;
      pwr_ack    <= 1'b0;
      hold       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        ST_ON: begin
          if (pwr_req) begin
            state <= ST_DRAIN;
            hold  <= host_req_valid & ~dev_req_ready;
          end
        end
        ST_DRAIN: begin
          if (req_hs) begin
            hold <= 1'b0;
          end
          if (!pwr_req) begin
            state <= ST_ON;
            hold  <= 1'b0;
          end else if (drain_done || tmo_hit) begin
            state      <= ST_ISO;
            isolate    <= 1'b1;
            hold       <= 1'b0;
            settle_cnt <= '0;
          end
        end
        ST_ISO: begin
          if (settle_last) begin
            state      <= ST_OFF;
            pwr_ack    <= 1'b1;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_OFF: begin
          if (!pwr_req) begin
            state      <= ST_WAKE;
            pwr_ack    <= 1'b0;
            settle_cnt <= '0;
          end
        end
        ST_WAKE: begin
          if (settle_last) begin
            state      <= ST_ON;
            isolate    <= 1'b0;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: begin
          state      <= ST_ON;
          isolate    <= 1'b0;
          pwr_ack    <= 1'b0;
          hold       <= 1'b0;
          settle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umi_isolate_ctrl.sv
// Directed scoreboard bench for umi_isolate_ctrl (OW=2, SETTLE=4).
// Timeout scenario runs when UMI_ISOLATE_CTRL_TIMEOUT_EN is defined.
module tb_umi_isolate_ctrl;

  localparam int CW      = 32;
  localparam int OW      = 2;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  localparam int S_OUT  = 0;
  localparam int S_ISO  = 1;
  localparam int S_ACK  = 2;
  localparam int S_HRDY = 3;
  localparam int S_DVAL = 4;
  localparam int S_TERR = 5;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          pwr_req = 1'b0;
  logic          pwr_ack;
  logic          isolate;
  logic          host_req_valid = 1'b0;
  logic [CW-1:0] host_req_cmd = '0;
  logic          host_req_ready;
  logic          dev_req_valid;
  logic          dev_req_ready = 1'b0;
  logic          resp_valid = 1'b0;
  logic          resp_ready = 1'b0;
  logic [OW-1:0] outstanding;
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
  logic          timeout_err;
`endif

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  umi_isolate_ctrl #(
    .CW(CW),
    .OW(OW),
    .SETTLE(SETTLE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .pwr_req(pwr_req),
    .pwr_ack(pwr_ack),
    .isolate(isolate),
    .host_req_valid(host_req_valid),
    .host_req_cmd(host_req_cmd),
    .host_req_ready(host_req_ready),
    .dev_req_valid(dev_req_valid),
    .dev_req_ready(dev_req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .outstanding(outstanding)
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_OUT:  return 8'(outstanding);
      S_ISO:  return 8'(isolate);
      S_ACK:  return 8'(pwr_ack);
      S_HRDY: return 8'(host_req_ready);
      S_DVAL: return 8'(dev_req_valid);
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
      S_TERR: return 8'(timeout_err);
`endif
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel,
                      input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    tick(2);
    push("rst_out", S_OUT, 0);
    push("rst_iso", S_ISO, 0);
    push("rst_ack", S_ACK, 0);
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    push("rst_terr", S_TERR, 0);
`endif
    check();

    // three reads fill the OW=2 counter
    nreset = 1'b1;
    host_req_valid = 1'b1;
    host_req_cmd = 32'h1;
    dev_req_ready = 1'b1;
    push("on_gate", S_HRDY, 1);
    push("on_dval", S_DVAL, 1);
    check();
    tick(3);
    push("three_reads", S_OUT, 3);
    push("full_bp", S_HRDY, 0);
    push("full_dval", S_DVAL, 0);
    check();

    // one response frees a slot, 4th read accepted
    resp_valid = 1'b1;
    resp_ready = 1'b1;
    tick();
    resp_valid = 1'b0;
    push("resp_free", S_OUT, 2);
    push("resp_free_rdy", S_HRDY, 1);
    check();
    tick();
    host_req_valid = 1'b0;
    push("fourth_read", S_OUT, 3);
    check();

    // power down: gate closes, drain three responses
    pwr_req = 1'b1;
    tick();
    host_req_valid = 1'b1;
    push("drain_closed", S_HRDY, 0);
    push("drain_dval", S_DVAL, 0);
    check();
    host_req_valid = 1'b0;
    resp_valid = 1'b1;
    tick(3);
    resp_valid = 1'b0;
    push("drained", S_OUT, 0);
    push("pre_iso", S_ISO, 0);
    check();
    tick();
    push("iso_entry", S_ISO, 1);
    push("iso_noack", S_ACK, 0);
    check();
    tick(SETTLE - 1);
    push("iso_settle_ack", S_ACK, 0);
    push("iso_settle_iso", S_ISO, 1);
    check();
    tick();
    push("off_ack", S_ACK, 1);
    check();

    // responses ignored while off
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    push("off_out", S_OUT, 0);
    check();

    // wake sequence
    pwr_req = 1'b0;
    tick();
    push("wake_ack", S_ACK, 0);
    push("wake_iso", S_ISO, 1);
    check();
    tick(SETTLE - 1);
    push("wake_settle", S_ISO, 1);
    check();
    tick();
    host_req_valid = 1'b1;
    host_req_cmd = 32'h1;
    dev_req_ready = 1'b1;
    push("wake_done_iso", S_ISO, 0);
    push("wake_done_rdy", S_HRDY, 1);
    check();
    tick();
    push("post_wake_read", S_OUT, 1);
    check();

    // pending request at power-down stays valid
    dev_req_ready = 1'b0;
    pwr_req = 1'b1;
    push("pend_dval_on", S_DVAL, 1);
    check();
    tick();
    push("hold_dval", S_DVAL, 1);
    push("hold_rdy", S_HRDY, 0);
    check();
    tick();
    push("hold_dval2", S_DVAL, 1);
    check();
    dev_req_ready = 1'b1;
    push("hold_hs_rdy", S_HRDY, 1);
    check();
    tick();
    push("hold_done_out", S_OUT, 2);
    push("hold_done_rdy", S_HRDY, 0);
    push("hold_done_dval", S_DVAL, 0);
    check();

    // abort drain with outstanding=2
    pwr_req = 1'b0;
    tick();
    push("abort_rdy", S_HRDY, 1);
    check();
    tick();
    host_req_valid = 1'b0;
    push("abort_traffic", S_OUT, 3);
    check();

    // simultaneous inc/dec at outstanding=1
    resp_valid = 1'b1;
    tick(2);
    push("down_to_1", S_OUT, 1);
    check();
    host_req_valid = 1'b1;
    host_req_cmd = 32'h3;
    push("simul_rdy", S_HRDY, 1);
    check();
    tick();
    push("simul_out", S_OUT, 1);
    check();
    resp_valid = 1'b0;
    host_req_cmd = 32'h2;
    tick();
    push("no_resp_op", S_OUT, 1);
    check();
    host_req_cmd = 32'hffff_ffe9;
    tick();
    host_req_valid = 1'b0;
    push("atomic_hi_bits", S_OUT, 2);
    check();

    // decrement at zero does not underflow
    resp_valid = 1'b1;
    tick(3);
    resp_valid = 1'b0;
    push("no_underflow", S_OUT, 0);
    check();

`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    // withheld response forces isolation at drain cycle 16
    host_req_valid = 1'b1;
    host_req_cmd = 32'h1;
    tick();
    host_req_valid = 1'b0;
    pwr_req = 1'b1;
    tick();
    tick(TIMEOUT - 1);
    push("tmo_pre_iso", S_ISO, 0);
    push("tmo_pre_err", S_TERR, 0);
    check();
    tick();
    push("tmo_iso", S_ISO, 1);
    push("tmo_err", S_TERR, 1);
    push("tmo_out", S_OUT, 0);
    check();
`else
    pwr_req = 1'b1;
    tick(2);
    push("iso_again", S_ISO, 1);
    check();
`endif

    // reset in the middle of ISO
    nreset = 1'b0;
    pwr_req = 1'b0;
    tick();
    nreset = 1'b1;
    host_req_valid = 1'b1;
    dev_req_ready = 1'b1;
    push("rst_iso_iso", S_ISO, 0);
    push("rst_iso_ack", S_ACK, 0);
    push("rst_iso_out", S_OUT, 0);
    push("rst_iso_gate", S_HRDY, 1);
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    push("rst_iso_terr", S_TERR, 0);
`endif
    check();
    host_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
